// File: rtl/issue_ibuffer.sv
// Per-warp decoded-instruction buffer with round-robin issue into a registered output stage.
// The *_n outputs expose the output-stage D-inputs so the scoreboard can look one cycle ahead.
module issue_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 2,
  parameter int REG_W     = 6,
  parameter int PC_W      = 32,
  parameter int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [WID_W-1:0] dec_wid,
  input  logic [PC_W-1:0]  dec_pc,
  input  logic             dec_wb,
  input  logic [REG_W-1:0] dec_rd,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic [REG_W-1:0] dec_rs3,
  output logic             ib_valid,
  input  logic             ib_ready,
  output logic [WID_W-1:0] ib_wid,
  output logic [PC_W-1:0]  ib_pc,
  output logic             ib_wb,
  output logic [REG_W-1:0] ib_rd,
  output logic [REG_W-1:0] ib_rs1,
  output logic [REG_W-1:0] ib_rs2,
  output logic [REG_W-1:0] ib_rs3,
  output logic [WID_W-1:0] ib_wid_n,
  output logic [REG_W-1:0] ib_rd_n,
  output logic [REG_W-1:0] ib_rs1_n,
  output logic [REG_W-1:0] ib_rs2_n,
  output logic [REG_W-1:0] ib_rs3_n
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PC_W + 1 + 4 * REG_W;

  logic [ENT_W-1:0]     mem  [NUM_WARPS][DEPTH];
  logic [CNT_W-1:0]     cnt  [NUM_WARPS];
  logic [PTR_W-1:0]     wptr [NUM_WARPS];
  logic [PTR_W-1:0]     rptr [NUM_WARPS];
  logic [WID_W-1:0]     rr;
  logic [WID_W-1:0]     rr_nxt;
  logic [WID_W:0]       cand;
  logic [WID_W-1:0]     sel;
  logic                 found;
  logic                 load;
  logic                 enq;
  logic                 deq;
  logic [NUM_WARPS-1:0] enq_vec;
  logic [NUM_WARPS-1:0] deq_vec;
  logic [ENT_W-1:0]     head;
  logic [ENT_W-1:0]     dec_ent;
  logic [WID_W-1:0]     wid_d;
  logic [PC_W-1:0]      pc_d;
  logic                 wb_d;
  logic [REG_W-1:0]     rd_d;
  logic [REG_W-1:0]     rs1_d;
  logic [REG_W-1:0]     rs2_d;
  logic [REG_W-1:0]     rs3_d;

  // Ready looks only at the pre-edge count, so a full FIFO never passes through.
  assign dec_ready = cnt[dec_wid] < CNT_W'(DEPTH);
  assign enq       = dec_valid & dec_ready;
  assign load      = ~ib_valid | ib_ready;
  assign dec_ent   = {dec_pc, dec_wb, dec_rd, dec_rs1, dec_rs2, dec_rs3};

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand = {1'b0, rr} + (WID_W+1)'(i);
      if (cand >= (WID_W+1)'(NUM_WARPS)) cand = cand - (WID_W+1)'(NUM_WARPS);
      if (!found && cnt[cand[WID_W-1:0]] != '0) begin
        found = 1'b1;
        sel   = cand[WID_W-1:0];
      end
    end
  end

  assign deq    = load & found;
  assign head   = mem[sel][rptr[sel]];
  assign rr_nxt = (sel == WID_W'(NUM_WARPS - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    enq_vec = '0;
    deq_vec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      enq_vec[w] = enq && (dec_wid == WID_W'(w));
      deq_vec[w] = deq && (sel == WID_W'(w));
    end
  end

  always_comb begin
    wid_d = ib_wid;
    pc_d  = ib_pc;
    wb_d  = ib_wb;
    rd_d  = ib_rd;
    rs1_d = ib_rs1;
    rs2_d = ib_rs2;
    rs3_d = ib_rs3;
    if (deq) begin
      wid_d = sel;
      {pc_d, wb_d, rd_d, rs1_d, rs2_d, rs3_d} = head;
    end
  end

  assign ib_wid_n = wid_d;
  assign ib_rd_n  = rd_d;
  assign ib_rs1_n = rs1_d;
  assign ib_rs2_n = rs2_d;
  assign ib_rs3_n = rs3_d;

  always_ff @(posedge clk) begin
    if (enq) mem[dec_wid][wptr[dec_wid]] <= dec_ent;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        cnt[w]  <= '0;
        wptr[w] <= '0;
        rptr[w] <= '0;
      end
      rr       <= '0;
      ib_valid <= 1'b0;
      ib_wid   <= '0;
      ib_pc    <= '0;
      ib_wb    <= 1'b0;
      ib_rd    <= '0;
      ib_rs1   <= '0;
      ib_rs2   <= '0;
      ib_rs3   <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (enq_vec[w]) wptr[w] <= wptr[w] + 1'b1;
        if (deq_vec[w]) rptr[w] <= rptr[w] + 1'b1;
        if (enq_vec[w] && !deq_vec[w])      cnt[w] <= cnt[w] + 1'b1;
        else if (!enq_vec[w] && deq_vec[w]) cnt[w] <= cnt[w] - 1'b1;
      end
      if (load) ib_valid <= found;
      if (deq) rr <= rr_nxt;
      ib_wid <= wid_d;
      ib_pc  <= pc_d;
      ib_wb  <= wb_d;
      ib_rd  <= rd_d;
      ib_rs1 <= rs1_d;
      ib_rs2 <= rs2_d;
      ib_rs3 <= rs3_d;
    end
  end

  a_dec_hold: assert property (@(posedge clk) disable iff (!reset)
    (dec_valid && !dec_ready) |=> (dec_valid && $stable(dec_ent) && $stable(dec_wid)));

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_cnt_chk
    a_cnt_ovf: assert property (@(posedge clk) disable iff (!reset)
      (enq_vec[g] && !deq_vec[g]) |-> (cnt[g] < CNT_W'(DEPTH)));
    a_cnt_udf: assert property (@(posedge clk) disable iff (!reset)
      deq_vec[g] |-> (cnt[g] != '0));
  end

endmodule

// File: tb/tb_issue_ibuffer.sv
// Scoreboard bench for issue_ibuffer: a queue-based reference model predicts issue order,
// a monitor compares every new presentation, ready and lookahead value against it.
module tb_issue_ibuffer;
  localparam int NW    = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [1:0]  wid;
    logic [31:0] pc;
    logic        wb;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rs3;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dec_valid = 1'b0;
  logic dec_ready;
  logic [1:0] dec_wid = '0;
  logic [31:0] dec_pc = '0;
  logic dec_wb = 1'b0;
  logic [5:0] dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0, dec_rs3 = '0;
  logic ib_valid;
  logic ib_ready = 1'b0;
  logic [1:0] ib_wid, ib_wid_n;
  logic [31:0] ib_pc;
  logic ib_wb;
  logic [5:0] ib_rd, ib_rs1, ib_rs2, ib_rs3;
  logic [5:0] ib_rd_n, ib_rs1_n, ib_rs2_n, ib_rs3_n;

  issue_ibuffer #(.NUM_WARPS(NW), .DEPTH(DEPTH), .REG_W(6), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_wid(dec_wid), .dec_pc(dec_pc),
    .dec_wb(dec_wb), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3),
    .ib_valid(ib_valid), .ib_ready(ib_ready), .ib_wid(ib_wid), .ib_pc(ib_pc), .ib_wb(ib_wb),
    .ib_rd(ib_rd), .ib_rs1(ib_rs1), .ib_rs2(ib_rs2), .ib_rs3(ib_rs3),
    .ib_wid_n(ib_wid_n), .ib_rd_n(ib_rd_n), .ib_rs1_n(ib_rs1_n), .ib_rs2_n(ib_rs2_n),
    .ib_rs3_n(ib_rs3_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: per-warp queues, a round-robin pointer and the presented slot.
  ent_t mq [NW][$];
  ent_t exp_q [$];
  bit   m_valid = 1'b0;
  int   m_rr = 0;
  bit   acc_flag = 1'b0;
  bit   m_acc, m_found;
  int   m_w;
  ent_t m_e;

  always @(posedge clk) begin
    if (reset) begin
      m_acc = dec_valid && (mq[dec_wid].size() < DEPTH);
      if (!m_valid || ib_ready) begin
        m_found = 1'b0;
        for (int i = 0; i < NW; i++) begin
          m_w = (m_rr + i) % NW;
          if (!m_found && mq[m_w].size() > 0) begin
            m_found = 1'b1;
            exp_q.push_back(mq[m_w].pop_front());
            m_rr = (m_w + 1) % NW;
          end
        end
        m_valid = m_found;
      end
      if (m_acc) begin
        m_e = '{wid: dec_wid, pc: dec_pc, wb: dec_wb, rd: dec_rd,
                rs1: dec_rs1, rs2: dec_rs2, rs3: dec_rs3};
        mq[dec_wid].push_back(m_e);
      end
      acc_flag = m_acc;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  bit          have_prev = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  logic [25:0] prev_n;
  ent_t        got;

  always @(negedge clk) begin
    if (!reset) begin
      have_prev  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      chk("ib_valid", ib_valid, m_valid);
      chk("dec_ready", dec_ready, mq[dec_wid].size() < DEPTH);
      if (have_prev)
        chk("lookahead", {ib_wid, ib_rd, ib_rs1, ib_rs2, ib_rs3}, prev_n);
      if (ib_valid && (!prev_valid || prev_ready)) begin
        got = {ib_wid, ib_pc, ib_wb, ib_rd, ib_rs1, ib_rs2, ib_rs3};
        if (exp_q.size() == 0) chk("unexpected_issue", got, '0);
        else chk("issue_data", got, exp_q.pop_front());
      end
      prev_n     = {ib_wid_n, ib_rd_n, ib_rs1_n, ib_rs2_n, ib_rs3_n};
      prev_valid = ib_valid;
      prev_ready = ib_ready;
      have_prev  = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_model();
    for (int w = 0; w < NW; w++) mq[w].delete();
    exp_q.delete();
    m_valid  = 1'b0;
    m_rr     = 0;
    acc_flag = 1'b0;
  endtask

  task automatic do_reset();
    dec_valid = 1'b0;
    reset = 1'b0;
    clear_model();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic enq(int w, logic [31:0] pc, logic [5:0] rd);
    int n;
    dec_valid = 1'b1;
    dec_wid   = 2'(w);
    dec_pc    = pc;
    dec_wb    = rd[0];
    dec_rd    = rd;
    dec_rs1   = rd + 6'd1;
    dec_rs2   = rd + 6'd2;
    dec_rs3   = rd + 6'd3;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_flag && n < 50);
    if (!acc_flag) chk("enq_accept_timeout", 0, 1);
    dec_valid = 1'b0;
  endtask

  logic [63:0] snap, snap_n;

  initial begin
    // Reset state
    #12;
    chk("rst_valid", ib_valid, 0);
    chk("rst_fields", {ib_wid, ib_pc, ib_wb, ib_rd, ib_rs1, ib_rs2, ib_rs3}, 0);
    chk("rst_lookahead", {ib_wid_n, ib_rd_n, ib_rs1_n, ib_rs2_n, ib_rs3_n}, 0);
    step();
    reset = 1'b1;

    // Single instruction latency and lookahead
    ib_ready = 1'b1;
    enq(1, 32'h80, 6'd5);
    #1;
    chk("t1_valid_before", ib_valid, 0);
    chk("t1_wid_n", ib_wid_n, 1);
    chk("t1_rd_n", ib_rd_n, 5);
    chk("t1_rs1_n", ib_rs1_n, 6);
    step();
    chk("t1_valid", ib_valid, 1);
    chk("t1_wid", ib_wid, 1);
    chk("t1_pc", ib_pc, 32'h80);
    chk("t1_rd", ib_rd, 5);

    // Round-robin order 0,1,2 then wrap to a late warp-0 instruction
    ib_ready = 1'b0;
    do_reset();
    enq(0, 32'h100, 6'd10);
    enq(1, 32'h110, 6'd11);
    enq(2, 32'h120, 6'd12);
    chk("t2_stalled_w0", {ib_valid, ib_wid}, {1'b1, 2'd0});
    ib_ready = 1'b1;
    step();
    chk("t2_issue_w1", ib_wid, 1);
    dec_valid = 1'b1; dec_wid = 2'd0; dec_pc = 32'h300; dec_rd = 6'd20;
    #1;
    chk("t2_ready_w0", dec_ready, 1);
    step();
    dec_valid = 1'b0;
    chk("t2_issue_w2", ib_wid, 2);
    step();
    chk("t2_issue_w0_wrap", {ib_wid, ib_pc}, {2'd0, 32'h300});
    step();
    chk("t2_idle", ib_valid, 0);

    // Full warp-3 FIFO blocks only warp 3
    ib_ready = 1'b0;
    enq(1, 32'h400, 6'd1);
    enq(3, 32'h430, 6'd3);
    enq(3, 32'h434, 6'd4);
    dec_wid = 2'd3;
    #1;
    chk("t3_full_w3", dec_ready, 0);
    dec_wid = 2'd0;
    #1;
    chk("t3_ready_w0", dec_ready, 1);
    dec_wid = 2'd3;
    ib_ready = 1'b1;
    step();
    ib_ready = 1'b0;
    #1;
    chk("t3_w3_ready_again", dec_ready, 1);
    chk("t3_w3_loaded", ib_wid, 3);

    // Stall for 5 cycles with other warps pending
    enq(0, 32'h500, 6'd7);
    enq(2, 32'h520, 6'd9);
    snap   = {ib_valid, ib_wid, ib_pc, ib_wb, ib_rd, ib_rs1, ib_rs2, ib_rs3};
    snap_n = {ib_wid_n, ib_rd_n, ib_rs1_n, ib_rs2_n, ib_rs3_n};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_regs", {ib_valid, ib_wid, ib_pc, ib_wb, ib_rd, ib_rs1, ib_rs2, ib_rs3}, snap);
      chk("t4_hold_n", {ib_wid_n, ib_rd_n, ib_rs1_n, ib_rs2_n, ib_rs3_n}, snap_n);
    end
    ib_ready = 1'b1;
    step();
    ib_ready = 1'b0;
    chk("t4_release_w0", {ib_wid, ib_pc}, {2'd0, 32'h500});

    // Asynchronous reset mid-cycle discards buffered work
    enq(1, 32'h610, 6'd15);
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    chk("t5_async_valid", ib_valid, 0);
    step();
    step();
    reset = 1'b1;
    ib_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_issue", ib_valid, 0);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(dec_valid && !acc_flag)) begin
        dec_valid = 1'($urandom_range(0, 1));
        dec_wid   = 2'($urandom_range(0, NW - 1));
        dec_pc    = $urandom;
        dec_wb    = 1'($urandom_range(0, 1));
        dec_rd    = 6'($urandom);
        dec_rs1   = 6'($urandom);
        dec_rs2   = 6'($urandom);
        dec_rs3   = 6'($urandom);
      end
      ib_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    if (dec_valid && !acc_flag) begin
      ib_ready = 1'b1;
      for (int i = 0; i < 20 && !acc_flag; i++) step();
    end
    dec_valid = 1'b0;
    ib_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("drain_exp_empty", exp_q.size(), 0);
    chk("drain_dut_idle", ib_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
